// File: rtl/cpu_fetch_unit.sv
// Instruction fetch / data access sequencer sharing one single-port RAM.
// Fetches into ir, serves load/store requests between instructions, supports halt/restart.
module cpu_fetch_unit #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] start_pc,
  input  logic [DATA_W-1:0] ram_r_data,
  input  logic              next_req,
  input  logic              br_en,
  input  logic              br_rel,
  input  logic [ADDR_W-1:0] br_off,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              halt,
  input  logic              restart,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_w_en,
  output logic [DATA_W-1:0] ram_w_data,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic              halted
);

  localparam int LAT_W = (RAM_LAT < 1) ? 1 : $clog2(RAM_LAT + 1);
  localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(RAM_LAT);

  typedef enum logic [2:0] {
    LOAD_PC, FETCH, READY, MEM_RD, MEM_WR, HALT
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] dar;
  logic [DATA_W-1:0] wdata_q;
  logic [LAT_W-1:0]  lat_cnt;

  always_comb begin
    ram_addr = pc;
    if (state == MEM_RD || state == MEM_WR) ram_addr = dar;
  end

  assign ram_w_data = wdata_q;

  // ir_valid, ram_w_en, mem_done and halted are registered: each is set on the
  // edge entering the cycle in which it must be high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD_PC;
      pc        <= '0;
      ir        <= '0;
      dar       <= '0;
      wdata_q   <= '0;
      mem_rdata <= '0;
      lat_cnt   <= '0;
      ir_valid  <= 1'b0;
      ram_w_en  <= 1'b0;
      mem_done  <= 1'b0;
      halted    <= 1'b0;
    end else begin
      ram_w_en <= 1'b0;
      mem_done <= 1'b0;
      case (state)
        LOAD_PC: begin
          pc      <= start_pc;
          lat_cnt <= '0;
          state   <= FETCH;
        end
        FETCH: begin
          if (lat_cnt == LAT_MAX) begin
            ir       <= ram_r_data;
            pc       <= pc + 1'b1;
            ir_valid <= 1'b1;
            state    <= READY;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        READY: begin
          if (halt) begin
            ir_valid <= 1'b0;
            halted   <= 1'b1;
            state    <= HALT;
          end else if (mem_req) begin
            dar      <= mem_addr;
            wdata_q  <= mem_wdata;
            lat_cnt  <= '0;
            ir_valid <= 1'b0;
            if (mem_we) begin
              ram_w_en <= 1'b1;
              mem_done <= 1'b1;
              state    <= MEM_WR;
            end else begin
              state <= MEM_RD;
            end
          end else if (next_req) begin
            ir_valid <= 1'b0;
            lat_cnt  <= '0;
            state    <= FETCH;
            if (br_en) pc <= br_rel ? pc + br_off : br_off;
          end
        end
        MEM_RD: begin
          if (lat_cnt == LAT_MAX) begin
            mem_rdata <= ram_r_data;
            ir_valid  <= 1'b1;
            state     <= READY;
          end else begin
            lat_cnt  <= lat_cnt + 1'b1;
            // pulse lands in the final count cycle, when the data is captured
            mem_done <= (LAT_W'(lat_cnt + 1'b1) == LAT_MAX);
          end
        end
        MEM_WR: begin
          ir_valid <= 1'b1;
          state    <= READY;
        end
        HALT: begin
          if (restart) begin
            halted <= 1'b0;
            state  <= LOAD_PC;
          end
        end
        default: state <= LOAD_PC;
      endcase
    end
  end

endmodule

// File: doc/cpu_fetch_unit.md
CPU_FETCH_UNIT -- requirements
Module: cpu_fetch_unit

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 8, address width; DATA_W, default 16, instruction/data width; RAM_LAT, default 1, RAM read latency in cycles (legal 1..4).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start_pc  input  ADDR_W  PC load value after reset and restart.
REQ-005 ram_r_data  input  DATA_W  RAM read data.
REQ-006 next_req  input  1  controller finished the current instruction; fetch the next one.
REQ-007 br_en  input  1  qualifies next_req; a taken branch.
REQ-008 br_rel  input  1  1 = PC-relative branch, 0 = absolute branch.
REQ-009 br_off  input  ADDR_W  branch offset, two's complement, or absolute target.
REQ-010 mem_req, mem_we  input  1 each  data access request; mem_we 1 = store.
REQ-011 mem_addr  input  ADDR_W  data address (datapath_out low bits).
REQ-012 mem_wdata  input  DATA_W  store data.
REQ-013 halt, restart  input  1 each  stop fetching; leave HALT.
REQ-014 ram_addr  output  ADDR_W; ram_w_en  output  1; ram_w_data  output  DATA_W.
REQ-015 ir  output  DATA_W  instruction register; ir_valid  output  1  ir holds a decodable instruction.
REQ-016 pc  output  ADDR_W  address of the next instruction.
REQ-017 mem_rdata  output  DATA_W  load data register; mem_done  output  1  one-cycle access-complete pulse; halted  output  1.

Function
REQ-018 States SHALL be LOAD_PC, FETCH, READY, MEM_RD, MEM_WR, HALT.
REQ-019 LOAD_PC SHALL last 1 cycle: pc <= start_pc, then go to FETCH with lat_cnt <= 0.
REQ-020 In FETCH, ram_addr SHALL be pc, held stable; lat_cnt increments each cycle; when lat_cnt == RAM_LAT: ir <= ram_r_data, pc <= pc+1 (mod 2^ADDR_W), go to READY.
REQ-021 In READY, ir_valid SHALL be 1, and only in READY; ram_addr = pc.
REQ-022 READY priority SHALL be halt > mem_req > next_req; lower-priority requests in the same cycle are dropped and must be reasserted.
REQ-023 On next_req with br_en=0, the block SHALL go to FETCH with pc unchanged.
REQ-024 On next_req with br_en=1, pc SHALL be loaded with pc+br_off (br_rel=1; pc is already instruction+1; wraps mod 2^ADDR_W) or br_off (br_rel=0), then go to FETCH.
REQ-025 On mem_req, dar SHALL be loaded with mem_addr and wdata_q with mem_wdata, then go to MEM_WR (mem_we=1) or MEM_RD (mem_we=0).
REQ-026 In MEM_WR/MEM_RD, ram_addr SHALL be dar; ram_w_data always SHALL be wdata_q.
REQ-027 MEM_WR SHALL last 1 cycle with ram_w_en=1 and mem_done=1, then return to READY; ram_w_en SHALL be 0 in every other state.
REQ-028 MEM_RD SHALL count lat_cnt 0..RAM_LAT; at lat_cnt == RAM_LAT, mem_rdata <= ram_r_data, mem_done=1 that cycle, then return to READY.
REQ-029 ir and pc SHALL be unchanged by data accesses.
REQ-030 In HALT, halted SHALL be 1 and ram_addr = pc; restart=1 SHALL go to LOAD_PC; all other requests are ignored.
REQ-031 next_req, mem_req and halt outside READY SHALL be ignored (no queuing).
REQ-032 lat_cnt SHALL be wide enough for RAM_LAT and reset to 0 on every entry to FETCH/MEM_RD.

Reset
REQ-033 rst_n low SHALL immediately force: state LOAD_PC, pc=0, ir=0, dar=0, wdata_q=0, mem_rdata=0, lat_cnt=0, ir_valid=0, ram_w_en=0, mem_done=0, halted=0.
REQ-034 Reset mid-access (including during MEM_WR) SHALL deassert ram_w_en asynchronously and abandon the access with no mem_done.
REQ-035 After rst_n rises, start_pc SHALL be sampled at the first clock edge.

Verification
REQ-036 RAM_LAT=1, start_pc=8'h10, mem[10]=16'hA5A5: release reset -> ir_valid=1 after 3rd edge, ir=16'hA5A5, pc=8'h11.
REQ-037 In READY with pc=8'h11: next_req, br_en=1, br_rel=1, br_off=8'hFE -> fetch from 8'h0F; pc=8'hFF, br_rel=0, br_off=8'h40 -> fetch from 8'h40; pc=8'hFF, no branch -> fetch 8'hFF, pc then 8'h00.
REQ-038 mem_req, mem_we=1, mem_addr=8'h80, mem_wdata=16'h1234 -> exactly one cycle with ram_w_en=1, ram_addr=8'h80, mem_done=1; ir, pc unchanged.
REQ-039 RAM_LAT=3, load from 8'h81 holding 16'hBEEF -> mem_done after 4 MEM_RD cycles, mem_rdata=16'hBEEF.
REQ-040 halt, mem_req and next_req asserted together -> HALT, no RAM write; restart -> pc=start_pc, refetch; rst_n low during MEM_WR -> ram_w_en drops before next edge.
